// File: rtl/axi4s_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiter.
package axi4s_pkg;

  typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

  localparam int unsigned MaxSlaves = 16;
  localparam int unsigned MaxIdxW   = 4;

  typedef struct packed {
    logic               valid;
    logic [MaxIdxW-1:0] idx;
  } rr_sel_t;

  // Reference round-robin pick: first set bit of req at or after ptr, modulo num.
  function automatic rr_sel_t rr_select(input logic [MaxSlaves-1:0] req,
                                        input logic [MaxIdxW-1:0]   ptr,
                                        input int unsigned          num);
    rr_sel_t     res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < MaxSlaves; i++) begin
      j = (32'(ptr) + i) % num;
      if (i < num && !res.valid && req[j[MaxIdxW-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = j[MaxIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin select: rotate by ptr, find first one, un-rotate.
module rr_priority_select
  import axi4s_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] onehot,
  output logic [IdxW-1:0]   idx,
  output logic              valid
);

  localparam logic [IdxW:0] NumVal = (IdxW+1)'(NumReq);

  logic [2*NumReq-1:0] req_dbl;
  logic [NumReq-1:0]   req_rot;
  logic [IdxW-1:0]     rot_idx;
  logic                found;
  logic [IdxW:0]       idx_sum;

  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NumReq-1:0];

  always_comb begin
    found   = 1'b0;
    rot_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        rot_idx = IdxW'(i);
      end
    end
  end

  assign idx_sum = {1'b0, rot_idx} + {1'b0, ptr};
  assign idx     = (idx_sum >= NumVal) ? IdxW'(idx_sum - NumVal) : idx_sum[IdxW-1:0];
  assign valid   = found;
  assign onehot  = found ? (NumReq'(1) << idx) : '0;

endmodule

// File: rtl/axi4s_rr_arbiter.sv
// Packet-level round-robin AXI4-Stream arbiter; grant is held until the tlast handshake.
module axi4s_rr_arbiter
  import axi4s_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned TDATA_WIDTH = 8,
  parameter int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int unsigned TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NUM_SLAVES-1:0]             s_tvalid,
  output logic [NUM_SLAVES-1:0]             s_tready,
  input  logic [NUM_SLAVES-1:0]             s_tlast,
  input  logic [NUM_SLAVES*TDATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SLAVES*TKEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_SLAVES*TSTRB_WIDTH-1:0] s_tstrb,
  input  logic [NUM_SLAVES*TUSER_WIDTH-1:0] s_tuser,
  input  logic [NUM_SLAVES*TDEST_WIDTH-1:0] s_tdest,
  input  logic [NUM_SLAVES*TID_WIDTH-1:0]   s_tid,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic [TDATA_WIDTH-1:0]            m_tdata,
  output logic [TKEEP_WIDTH-1:0]            m_tkeep,
  output logic [TSTRB_WIDTH-1:0]            m_tstrb,
  output logic [TUSER_WIDTH-1:0]            m_tuser,
  output logic [TDEST_WIDTH-1:0]            m_tdest,
  output logic [TID_WIDTH-1:0]              m_tid,
  output logic [NUM_SLAVES-1:0]             grant
);

  localparam int unsigned IdxW = $clog2(NUM_SLAVES);

  arb_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] grant_q, grant_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic [IdxW-1:0]       sel_idx;
  logic                  sel_valid;
  logic [NUM_SLAVES-1:0] mux_sel;
  logic                  handshake;

  rr_priority_select #(
    .NumReq (NUM_SLAVES)
  ) u_select (
    .req    (s_tvalid),
    .ptr    (rr_ptr_q),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );

  // grant_q is all-zero outside StLocked, so valid/ready gate to zero when idle.
  assign m_tvalid  = |(s_tvalid & grant_q);
  assign s_tready  = grant_q & {NUM_SLAVES{m_tready}};
  assign handshake = m_tvalid & m_tready & m_tlast;
  assign grant     = grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d  = StLocked;
          grant_d  = sel_onehot;
          rr_ptr_d = (sel_idx == IdxW'(NUM_SLAVES - 1)) ? '0 : sel_idx + IdxW'(1);
        end
      end
      StLocked: begin
        if (handshake) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Idle cycles still drive slave 0's payload so the outputs never float to X.
  assign mux_sel = (state_q == StLocked) ? grant_q : NUM_SLAVES'(1);

  always_comb begin
    m_tlast = 1'b0;
    m_tdata = '0;
    m_tkeep = '0;
    m_tstrb = '0;
    m_tuser = '0;
    m_tdest = '0;
    m_tid   = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      m_tlast = m_tlast | (s_tlast[i] & mux_sel[i]);
      m_tdata = m_tdata | (s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH] & {TDATA_WIDTH{mux_sel[i]}});
      m_tkeep = m_tkeep | (s_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH] & {TKEEP_WIDTH{mux_sel[i]}});
      m_tstrb = m_tstrb | (s_tstrb[i*TSTRB_WIDTH +: TSTRB_WIDTH] & {TSTRB_WIDTH{mux_sel[i]}});
      m_tuser = m_tuser | (s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH] & {TUSER_WIDTH{mux_sel[i]}});
      m_tdest = m_tdest | (s_tdest[i*TDEST_WIDTH +: TDEST_WIDTH] & {TDEST_WIDTH{mux_sel[i]}});
      m_tid   = m_tid   | (s_tid[i*TID_WIDTH +: TID_WIDTH]       & {TID_WIDTH{mux_sel[i]}});
    end
  end

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// Directed self-checking bench for axi4s_rr_arbiter (4 slaves, 8-bit data).
module tb_axi4s_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  localparam logic [3:0] RrGrant [18] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                                          4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2};
  localparam logic [7:0] RrData  [18] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11, 8'h00, 8'h20,
                                          8'h21, 8'h00, 8'h30, 8'h31, 8'h00, 8'h00, 8'h01, 8'h00,
                                          8'h10, 8'h11};
  localparam logic       BpRdy   [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [7:0] BpData  [6]  = '{8'hD0, 8'hD1, 8'hD1, 8'hD1, 8'hD2, 8'hD2};

  logic           aclk = 1'b0;
  logic           areset;
  logic [N-1:0]   s_tvalid, s_tready, s_tlast;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tkeep, s_tstrb, s_tuser, s_tdest, s_tid;
  logic           m_tvalid, m_tready, m_tlast;
  logic [W-1:0]   m_tdata;
  logic           m_tkeep, m_tstrb, m_tuser, m_tdest, m_tid;
  logic [N-1:0]   grant;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4s_rr_arbiter #(
    .NUM_SLAVES  (N),
    .TDATA_WIDTH (W)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tstrb  (s_tstrb),
    .s_tuser  (s_tuser),
    .s_tdest  (s_tdest),
    .s_tid    (s_tid),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tstrb  (m_tstrb),
    .m_tuser  (m_tuser),
    .m_tdest  (m_tdest),
    .m_tid    (m_tid),
    .grant    (grant)
  );

  task automatic drive_idle();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    drive_idle();
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset   = 1'b1;
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;
    m_tready = 1'b1;
    repeat (3) begin
      @(negedge aclk); #1;
      checks++;
      if (m_tvalid !== 1'b0) begin
        errors++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid);
      end
      checks++;
      if (grant !== 4'b0000) begin
        errors++; $display("FAIL reset_grant: got %b want 0000", grant);
      end
      checks++;
      if (s_tready !== 4'b0000) begin
        errors++; $display("FAIL reset_s_tready: got %b want 0000", s_tready);
      end
    end
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL reset_release_idle: got %b want 0000", grant);
    end
    @(negedge aclk); #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0001", grant);
    end
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++; $display("FAIL reset_first_valid: got %b want 1", m_tvalid);
    end
    @(negedge aclk);
    drive_idle();
  endtask

  task automatic test_single();
    logic [7:0] exp;
    do_reset();
    @(negedge aclk);
    s_tvalid        = 4'b0100;
    s_tdata[16 +: 8] = 8'h10;
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL single_req_cycle_valid: got %b want 0", m_tvalid);
    end
    checks++;
    if (m_tid !== 1'b0) begin
      errors++; $display("FAIL single_idle_tid: got %b want 0", m_tid);
    end
    for (int b = 0; b < 4; b++) begin
      exp = 8'(8'h10 + b);
      @(negedge aclk);
      s_tdata[16 +: 8] = exp;
      s_tlast[2]       = (b == 3);
      #1;
      checks++;
      if (grant !== 4'b0100) begin
        errors++; $display("FAIL single_grant beat %0d: got %b want 0100", b, grant);
      end
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp) begin
        errors++; $display("FAIL single_data beat %0d: got v=%b d=%h want v=1 d=%h",
                           b, m_tvalid, m_tdata, exp);
      end
      checks++;
      if (s_tready !== 4'b0100 || m_tlast !== (b == 3)) begin
        errors++; $display("FAIL single_ready_last beat %0d: got rdy=%b last=%b", b, s_tready,
                           m_tlast);
      end
      checks++;
      if (m_tid !== 1'b1) begin
        errors++; $display("FAIL single_tid beat %0d: got %b want 1", b, m_tid);
      end
    end
    @(negedge aclk);
    drive_idle();
    #1;
    checks++;
    if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL single_exit: got grant=%b v=%b want 0000/0", grant, m_tvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] cnt;
    do_reset();
    cnt = '0;
    for (int c = 0; c < 18; c++) begin
      @(negedge aclk);
      s_tvalid = 4'hF;
      for (int i = 0; i < 4; i++) s_tdata[i*8 +: 8] = {2'b00, 2'(i), 3'b000, cnt[i]};
      s_tlast = cnt;
      #1;
      checks++;
      if (grant !== RrGrant[c]) begin
        errors++; $display("FAIL rr_grant cycle %0d: got %b want %b", c, grant, RrGrant[c]);
      end
      checks++;
      if (m_tvalid !== (RrGrant[c] != 4'h0)) begin
        errors++; $display("FAIL rr_gap cycle %0d: got v=%b", c, m_tvalid);
      end
      if (RrGrant[c] != 4'h0) begin
        checks++;
        if (m_tdata !== RrData[c] || m_tlast !== RrData[c][0]) begin
          errors++; $display("FAIL rr_data cycle %0d: got d=%h l=%b want d=%h", c, m_tdata,
                             m_tlast, RrData[c]);
        end
      end
      cnt = cnt ^ (s_tready & s_tvalid);
    end
    @(negedge aclk);
    drive_idle();
  endtask

  task automatic test_no_interleave();
    do_reset();
    @(negedge aclk);
    s_tvalid        = 4'b0011;
    s_tdata[0 +: 8] = 8'hA0;
    s_tdata[8 +: 8] = 8'hB0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 8'hA0) begin
      errors++; $display("FAIL ni_idle_payload: got v=%b d=%h want 0/a0", m_tvalid, m_tdata);
    end
    @(negedge aclk); #1;
    checks++;
    if (grant !== 4'b0001 || m_tdata !== 8'hA0 || s_tready !== 4'b0001) begin
      errors++; $display("FAIL ni_first_beat: got g=%b d=%h r=%b", grant, m_tdata, s_tready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      s_tvalid[0]     = 1'b0;
      s_tdata[0 +: 8] = 8'hA1;
      #1;
      checks++;
      if (grant !== 4'b0001 || m_tvalid !== 1'b0 || s_tready[1] !== 1'b0) begin
        errors++; $display("FAIL ni_stall %0d: got g=%b v=%b r=%b", k, grant, m_tvalid, s_tready);
      end
    end
    @(negedge aclk);
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'hA1 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL ni_last_beat: got v=%b d=%h l=%b", m_tvalid, m_tdata, m_tlast);
    end
    @(negedge aclk);
    s_tvalid[0] = 1'b0;
    s_tlast     = '0;
    #1;
    checks++;
    if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL ni_gap: got g=%b v=%b want 0000/0", grant, m_tvalid);
    end
    @(negedge aclk); #1;
    checks++;
    if (grant !== 4'b0010 || m_tdata !== 8'hB0) begin
      errors++; $display("FAIL ni_next_grant: got g=%b d=%h want 0010/b0", grant, m_tdata);
    end
    @(negedge aclk);
    drive_idle();
  endtask

  task automatic test_backpressure();
    int beat;
    do_reset();
    beat = 0;
    @(negedge aclk);
    s_tvalid         = 4'b1000;
    s_tdata[24 +: 8] = 8'hD0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL bp_req_cycle: got v=%b want 0", m_tvalid);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      m_tready         = BpRdy[c];
      s_tdata[24 +: 8] = 8'(8'hD0 + beat);
      s_tlast[3]       = (beat == 2);
      #1;
      checks++;
      if (grant !== 4'b1000) begin
        errors++; $display("FAIL bp_grant cycle %0d: got %b want 1000", c, grant);
      end
      checks++;
      if (m_tdata !== BpData[c] || m_tlast !== (BpData[c] == 8'hD2)) begin
        errors++; $display("FAIL bp_data cycle %0d: got d=%h l=%b want d=%h", c, m_tdata,
                           m_tlast, BpData[c]);
      end
      checks++;
      if (s_tready !== {BpRdy[c], 3'b000}) begin
        errors++; $display("FAIL bp_ready cycle %0d: got %b want %b", c, s_tready,
                           {BpRdy[c], 3'b000});
      end
      if (s_tready[3]) beat++;
    end
    @(negedge aclk);
    drive_idle();
    #1;
    checks++;
    if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL bp_exit: got g=%b v=%b want 0000/0", grant, m_tvalid);
    end
    checks++;
    if (beat !== 3) begin
      errors++; $display("FAIL bp_beat_count: got %0d want 3", beat);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    @(negedge aclk);
    s_tvalid         = 4'b0100;
    s_tdata[16 +: 8] = 8'h40;
    @(negedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h40) begin
      errors++; $display("FAIL mr_beat1: got v=%b d=%h want 1/40", m_tvalid, m_tdata);
    end
    @(negedge aclk);
    s_tdata[16 +: 8] = 8'h41;
    #1;
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++; $display("FAIL mr_beat2_valid: got %b want 1", m_tvalid);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || grant !== 4'b0000 || s_tready !== 4'b0000) begin
      errors++; $display("FAIL mr_async_drop: got v=%b g=%b r=%b", m_tvalid, grant, s_tready);
    end
    @(negedge aclk);
    areset   = 1'b0;
    s_tvalid = 4'b1010;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL mr_idle_after: got %b want 0000", grant);
    end
    @(negedge aclk); #1;
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL mr_ptr_reset_grant: got %b want 0010", grant);
    end
    @(negedge aclk);
    drive_idle();
  endtask

  initial begin
    areset  = 1'b1;
    s_tkeep = '1;
    s_tstrb = '1;
    s_tuser = '0;
    s_tdest = '0;
    s_tid   = 4'b0100;
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_no_interleave();
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
